// File: rtl/mat_cache_reader_pkg.sv
// Shared matrix-cache types.
//   MatDataReadOp_t  : cache read mode (row / column / diagonal)
//   MatReaderState_t : drain sequencer state, exported for debug
//   mat_word_t       : one vector element, IEEE-754 single-precision bit pattern
package mat_cache_reader_pkg;

    typedef enum logic [1:0] {
        MAT_DATA_READ_ROW  = 2'd0,
        MAT_DATA_READ_COL  = 2'd1,
        MAT_DATA_READ_DIAG = 2'd2
    } MatDataReadOp_t;

    typedef enum logic {
        MAT_READER_IDLE   = 1'b0,
        MAT_READER_STREAM = 1'b1
    } MatReaderState_t;

    localparam int MAT_WORD_BITS = 32;

    // Elements are carried as raw float32 bit patterns; nothing here does
    // arithmetic on them, so bit-exact transport is all that matters.
    typedef logic [MAT_WORD_BITS-1:0] mat_word_t;

endpackage

// File: rtl/mat_cache_reader_if.sv
// Vector beat stream from the cache reader to its consumer.
//   out_data  : WIDTH float32 elements, element 0 in the low word
//   out_index : beat index (the read_param the beat was fetched with)
//   out_last  : set on the final beat of a drain
//   out_valid : producer has a beat
//   out_ready : consumer accepts the beat
// Handshake: a beat transfers on a rising clock edge where out_valid and
// out_ready are both high. Once raised, out_valid stays high with a stable
// payload until that transfer happens; ready may toggle freely.
interface mat_cache_reader_if #(
    parameter int WIDTH = 4
) ();
    import mat_cache_reader_pkg::*;

    localparam int IW = $clog2(WIDTH);

    logic [WIDTH-1:0][MAT_WORD_BITS-1:0] out_data;
    logic [IW-1:0]                       out_index;
    logic                                out_last;
    logic                                out_valid;
    logic                                out_ready;

    modport master (
        output out_data, out_index, out_last, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data, out_index, out_last, out_valid,
        output out_ready
    );

endinterface

// File: rtl/mat_vec_out_reg.sv
// WIDTH-wide vector payload register with valid/ready hold logic.
//   clock, reset : rising-edge clock, async active-high reset
//   load_i       : capture data_i/index_i/last_i and raise valid
//   ready_i      : consumer ready; drops valid when nothing new is loaded
//   data_o/index_o/last_o/valid_o : registered beat
// The producer must only assert load_i when !valid_o || ready_i, so a
// pending beat is never overwritten before it has been taken.
module mat_vec_out_reg
    import mat_cache_reader_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                load_i,
    input  logic [WIDTH-1:0][MAT_WORD_BITS-1:0] data_i,
    input  logic [IW-1:0]                       index_i,
    input  logic                                last_i,
    input  logic                                ready_i,
    output logic [WIDTH-1:0][MAT_WORD_BITS-1:0] data_o,
    output logic [IW-1:0]                       index_o,
    output logic                                last_o,
    output logic                                valid_o
);

    logic [WIDTH-1:0][MAT_WORD_BITS-1:0] data_q;
    logic [IW-1:0]                       index_q;
    logic                                last_q;
    logic                                valid_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            index_q <= index_i;
            last_q  <= last_i;
            valid_q <= 1'b1;
        end else if (valid_q && ready_i) begin
            // Beat taken with nothing behind it; payload keeps its last value.
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign index_o = index_q;
    assign last_o  = last_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/mat_cache_reader.sv
// Drain sequencer for one matrix-cache slot.
//   clock, reset                 : rising-edge clock, async active-high reset
//   start, start_op, start_addr* : drain request, taken only when !busy
//   read_op, read_addr*, read_param : cache read port (registered)
//   data_out                     : combinational cache read data
//   out_if                       : beat stream toward the consumer
//   busy                         : drain running or a beat still pending
//   dbg_state                    : current sequencer state
// A drain issues WIDTH reads with read_param 0..WIDTH-1. Each cache response
// is captured in the output register on the edge where the stage can take
// it, so under backpressure the counter (and so read_param) simply freezes.
module mat_cache_reader
    import mat_cache_reader_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int CACHE_SIZE = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  MatDataReadOp_t                      start_op,
    input  logic [$clog2(CACHE_SIZE)-1:0]       start_addr1,
    input  logic [$clog2(CACHE_SIZE)-1:0]       start_addr2,
    output MatDataReadOp_t                      read_op,
    output logic [$clog2(CACHE_SIZE)-1:0]       read_addr1,
    output logic [$clog2(CACHE_SIZE)-1:0]       read_addr2,
    output logic [$clog2(WIDTH)-1:0]            read_param,
    input  logic [WIDTH-1:0][MAT_WORD_BITS-1:0] data_out,
    mat_cache_reader_if.master                  out_if,
    output logic                                busy,
    output MatReaderState_t                     dbg_state
);

    localparam int IW = $clog2(WIDTH);
    localparam int AW = $clog2(CACHE_SIZE);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    MatReaderState_t state_q;
    MatDataReadOp_t  op_q;
    logic [AW-1:0]   addr1_q;
    logic [AW-1:0]   addr2_q;
    logic [IW-1:0]   cnt_q;

    logic                                valid;
    logic                                load;
    logic [WIDTH-1:0][MAT_WORD_BITS-1:0] beat_data;
    logic [IW-1:0]                       beat_index;
    logic                                beat_last;

    // The output stage can take a new beat when it is empty or its current
    // beat transfers on this same edge.
    assign load = (state_q == MAT_READER_STREAM) && (!valid || out_if.out_ready);
    assign busy = (state_q == MAT_READER_STREAM) || valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= MAT_READER_IDLE;
            op_q    <= MAT_DATA_READ_ROW;
            addr1_q <= '0;
            addr2_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                MAT_READER_IDLE: begin
                    // In IDLE busy reflects a still-pending last beat.
                    if (start && !busy) begin
                        op_q    <= start_op;
                        addr1_q <= start_addr1;
                        addr2_q <= start_addr2;
                        cnt_q   <= '0;
                        state_q <= MAT_READER_STREAM;
                    end
                end
                MAT_READER_STREAM: begin
                    if (load) begin
                        if (cnt_q == LAST_IDX) begin
                            cnt_q   <= '0;
                            state_q <= MAT_READER_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    mat_vec_out_reg #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_out_reg (
        .clock   (clock),
        .reset   (reset),
        .load_i  (load),
        .data_i  (data_out),
        .index_i (cnt_q),
        .last_i  (cnt_q == LAST_IDX),
        .ready_i (out_if.out_ready),
        .data_o  (beat_data),
        .index_o (beat_index),
        .last_o  (beat_last),
        .valid_o (valid)
    );

    assign out_if.out_data  = beat_data;
    assign out_if.out_index = beat_index;
    assign out_if.out_last  = beat_last;
    assign out_if.out_valid = valid;

    assign read_op    = op_q;
    assign read_addr1 = addr1_q;
    assign read_addr2 = addr2_q;
    assign read_param = cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mat_cache_reader.sv
// Bench for mat_cache_reader with a behavioural matrix cache model.
module tb_mat_cache_reader;
    import mat_cache_reader_pkg::*;

    localparam int WIDTH      = 4;
    localparam int CACHE_SIZE = 4;
    localparam int IW         = 2;
    localparam int AW         = 2;
    localparam int BW         = WIDTH * 32 + IW + 1;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- DUT signals ----------------
    logic                      start = 1'b0;
    MatDataReadOp_t            start_op = MAT_DATA_READ_ROW;
    logic [AW-1:0]             start_addr1 = '0;
    logic [AW-1:0]             start_addr2 = '0;
    MatDataReadOp_t            read_op;
    logic [AW-1:0]             read_addr1;
    logic [AW-1:0]             read_addr2;
    logic [IW-1:0]             read_param;
    logic [WIDTH-1:0][31:0]    data_out;
    logic                      busy;
    MatReaderState_t           dbg_state;

    mat_cache_reader_if #(.WIDTH(WIDTH)) out_if ();

    mat_cache_reader #(
        .WIDTH      (WIDTH),
        .CACHE_SIZE (CACHE_SIZE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .start_op    (start_op),
        .start_addr1 (start_addr1),
        .start_addr2 (start_addr2),
        .read_op     (read_op),
        .read_addr1  (read_addr1),
        .read_addr2  (read_addr2),
        .read_param  (read_param),
        .data_out    (data_out),
        .out_if      (out_if.master),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // ---------------- cache model ----------------
    logic [31:0] mem [CACHE_SIZE][WIDTH][WIDTH];

    function automatic logic [31:0] i2f(input int n);
        int p;
        logic [31:0] m;
        if (n == 0) return 32'h0;
        p = 0;
        for (int b = 0; b < 16; b++) if (((n >> b) & 1) == 1) p = b;
        m = (32'(n) << (23 - p)) & 32'h007f_ffff;
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    function automatic logic [WIDTH-1:0][31:0] mk_vec(input int a, input int b, input int c, input int d);
        return {i2f(d), i2f(c), i2f(b), i2f(a)};
    endfunction

    // Diagonal k: element j comes from row j, column (j+k) mod WIDTH;
    // even elements from slot addr1, odd elements from slot addr2.
    function automatic logic [WIDTH-1:0][31:0] read_vec(input MatDataReadOp_t op, input logic [AW-1:0] a1,
                                                        input logic [AW-1:0] a2, input int k);
        logic [WIDTH-1:0][31:0] v;
        for (int j = 0; j < WIDTH; j++) begin
            case (op)
                MAT_DATA_READ_ROW: v[j] = mem[a1][k][j];
                MAT_DATA_READ_COL: v[j] = mem[a1][j][k];
                default:           v[j] = mem[(j % 2 == 1) ? a2 : a1][j][(j + k) % WIDTH];
            endcase
        end
        return v;
    endfunction

    assign data_out = read_vec(read_op, read_addr1, read_addr2, int'(read_param));

    // ---------------- scoreboard ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    int beat_cnt     = 0;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] mon_exp;
    logic [BW-1:0] mon_got;

    always @(negedge clock) begin
        if (!reset && out_if.out_valid && out_if.out_ready) begin
            tests_run++;
            beat_cnt++;
            mon_got = {out_if.out_data, out_if.out_index, out_if.out_last};
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL beat_unexpected: got beat idx %0d, expected no beat", out_if.out_index);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    tests_failed++;
                    $display("FAIL beat_payload: got %h, expected %h", mon_got, mon_exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_drain(input MatDataReadOp_t op, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        for (int k = 0; k < WIDTH; k++)
            exp_q.push_back({read_vec(op, a1, a2, k), IW'(k), (k == WIDTH - 1)});
    endtask

    // Start is high for exactly one cycle ("cycle 0"); returns early in cycle 1.
    task automatic start_drain(input MatDataReadOp_t op, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        @(posedge clock);
        #1;
        start       = 1'b1;
        start_op    = op;
        start_addr1 = a1;
        start_addr2 = a2;
        push_drain(op, a1, a2);
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clock);
            if (!busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1;
        #2;
        tests_run++;
        if (out_if.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b, expected 0", out_if.out_valid); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        tests_run++;
        if (read_param !== '0 || read_addr1 !== '0 || read_addr2 !== '0 || read_op !== MAT_DATA_READ_ROW) begin
            tests_failed++;
            $display("FAIL reset_read_port: got op %0d a1 %0d a2 %0d p %0d, expected all 0", read_op, read_addr1, read_addr2, read_param);
        end
        tests_run++;
        if (out_if.out_data !== '0 || out_if.out_index !== '0 || out_if.out_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_payload: got %h idx %0d last %b, expected zeros", out_if.out_data, out_if.out_index, out_if.out_last);
        end
        tests_run++;
        if (dbg_state !== MAT_READER_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d, expected IDLE", dbg_state); end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_row;
        bit ok;
        out_if.out_ready = 1'b1;
        beat_cnt = 0;
        start_drain(MAT_DATA_READ_ROW, 2'd0, 2'd0);
        @(negedge clock);  // cycle 1
        tests_run++;
        if (out_if.out_valid !== 1'b0) begin tests_failed++; $display("FAIL row_latency_c1: got valid %b, expected 0", out_if.out_valid); end
        for (int k = 0; k < WIDTH; k++) begin
            @(negedge clock);  // cycles 2..5
            tests_run++;
            if (out_if.out_valid !== 1'b1 || out_if.out_index !== IW'(k) || out_if.out_last !== (k == WIDTH - 1)) begin
                tests_failed++;
                $display("FAIL row_beat_timing: cycle %0d got valid %b idx %0d last %b, expected 1 %0d %b",
                         k + 2, out_if.out_valid, out_if.out_index, out_if.out_last, k, (k == WIDTH - 1));
            end
            if (k == 0) begin
                tests_run++;
                if (out_if.out_data !== mk_vec(4, 6, 1, 6)) begin
                    tests_failed++;
                    $display("FAIL row_beat0_const: got %h, expected %h", out_if.out_data, mk_vec(4, 6, 1, 6));
                end
            end
        end
        @(negedge clock);  // cycle 6
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL row_busy_c6: got %b, expected 0", busy); end
        wait_idle(20, ok);
        tests_run++;
        if (!ok || beat_cnt != WIDTH) begin tests_failed++; $display("FAIL row_done: got done %b beats %0d, expected 1 4", ok, beat_cnt); end
    endtask

    task automatic test_col;
        bit ok;
        out_if.out_ready = 1'b1;
        beat_cnt = 0;
        start_drain(MAT_DATA_READ_COL, 2'd0, 2'd0);
        @(negedge clock);
        @(negedge clock);  // cycle 2
        tests_run++;
        if (out_if.out_valid !== 1'b1 || out_if.out_data !== mk_vec(4, 1, 3, 9)) begin
            tests_failed++;
            $display("FAIL col_beat0_const: got valid %b data %h, expected 1 %h", out_if.out_valid, out_if.out_data, mk_vec(4, 1, 3, 9));
        end
        wait_idle(20, ok);
        tests_run++;
        if (!ok || beat_cnt != WIDTH) begin tests_failed++; $display("FAIL col_done: got done %b beats %0d, expected 1 4", ok, beat_cnt); end
    endtask

    task automatic test_diag(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        bit ok;
        out_if.out_ready = 1'b1;
        beat_cnt = 0;
        start_drain(MAT_DATA_READ_DIAG, a1, a2);
        wait_idle(20, ok);
        tests_run++;
        if (!ok || beat_cnt != WIDTH) begin tests_failed++; $display("FAIL diag_done: got done %b beats %0d, expected 1 4", ok, beat_cnt); end
    endtask

    task automatic test_backpressure;
        bit ok;
        out_if.out_ready = 1'b0;
        beat_cnt = 0;
        start_drain(MAT_DATA_READ_ROW, 2'd0, 2'd0);
        @(negedge clock);  // cycle 1
        for (int c = 2; c <= 4; c++) begin
            @(negedge clock);
            tests_run++;
            if (out_if.out_valid !== 1'b1 || out_if.out_data !== mk_vec(4, 6, 1, 6) || out_if.out_index !== '0
                || read_param !== IW'(1)) begin
                tests_failed++;
                $display("FAIL bp_hold: cycle %0d got valid %b data %h idx %0d param %0d, expected 1 %h 0 1",
                         c, out_if.out_valid, out_if.out_data, out_if.out_index, read_param, mk_vec(4, 6, 1, 6));
            end
        end
        @(posedge clock);
        #1;
        out_if.out_ready = 1'b1;
        wait_idle(20, ok);
        tests_run++;
        if (!ok || beat_cnt != WIDTH) begin tests_failed++; $display("FAIL bp_done: got done %b beats %0d, expected 1 4", ok, beat_cnt); end
    endtask

    task automatic test_start_ignored;
        bit ok;
        out_if.out_ready = 1'b1;
        beat_cnt = 0;
        start_drain(MAT_DATA_READ_ROW, 2'd0, 2'd0);
        start    = 1'b1;  // cycles 1..6: keep requesting a column drain
        start_op = MAT_DATA_READ_COL;
        repeat (5) @(posedge clock);
        #1;  // cycle 6: previous drain fully transferred
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL ign_busy_c6: got %b, expected 0", busy); end
        push_drain(MAT_DATA_READ_COL, 2'd0, 2'd0);
        @(posedge clock);
        #1;
        start = 1'b0;
        tests_run++;
        if (dbg_state !== MAT_READER_STREAM || read_op !== MAT_DATA_READ_COL) begin
            tests_failed++;
            $display("FAIL ign_restart: got state %0d op %0d, expected STREAM COL", dbg_state, read_op);
        end
        wait_idle(20, ok);
        tests_run++;
        if (!ok || beat_cnt != 2 * WIDTH) begin tests_failed++; $display("FAIL ign_done: got done %b beats %0d, expected 1 8", ok, beat_cnt); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit found;
        out_if.out_ready = 1'b1;
        start_drain(MAT_DATA_READ_ROW, 2'd0, 2'd0);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (out_if.out_valid && out_if.out_index == IW'(2)) begin
                found = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("FAIL rst_mid_beat2: got no beat 2, expected beat 2"); end
        reset = 1'b1;
        #1;
        tests_run++;
        if (out_if.out_valid !== 1'b0 || busy !== 1'b0 || read_param !== '0 || dbg_state !== MAT_READER_IDLE) begin
            tests_failed++;
            $display("FAIL rst_mid_async: got valid %b busy %b param %0d state %0d, expected 0 0 0 IDLE",
                     out_if.out_valid, busy, read_param, dbg_state);
        end
        exp_q.delete();
        #2;
        reset = 1'b0;
        beat_cnt = 0;
        start_drain(MAT_DATA_READ_ROW, 2'd0, 2'd0);
        wait_idle(20, ok);
        tests_run++;
        if (!ok || beat_cnt != WIDTH) begin tests_failed++; $display("FAIL rst_mid_redo: got done %b beats %0d, expected 1 4", ok, beat_cnt); end
    endtask

    task automatic test_random_ready;
        bit ok;
        MatDataReadOp_t op;
        for (int d = 0; d < 4; d++) begin
            op = MatDataReadOp_t'($urandom_range(0, 2));
            beat_cnt = 0;
            start_drain(op, AW'($urandom_range(0, CACHE_SIZE - 1)), AW'($urandom_range(0, CACHE_SIZE - 1)));
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(posedge clock);
                #1;
                out_if.out_ready = 1'($urandom_range(0, 1));
                if (!busy && exp_q.size() == 0) begin
                    ok = 1'b1;
                    break;
                end
            end
            tests_run++;
            if (!ok || beat_cnt != WIDTH) begin tests_failed++; $display("FAIL rand_drain: got done %b beats %0d, expected 1 4", ok, beat_cnt); end
        end
        out_if.out_ready = 1'b1;
    endtask

    // ---------------- sequence ----------------
    int rows0[4][4] = '{'{4, 6, 1, 6}, '{1, 2, 3, 4}, '{3, 3, 3, 3}, '{9, 7, 5, 3}};

    initial begin
        out_if.out_ready = 1'b1;
        for (int r = 0; r < WIDTH; r++)
            for (int c = 0; c < WIDTH; c++) begin
                mem[0][r][c] = i2f(rows0[r][c]);
                for (int s = 1; s < CACHE_SIZE; s++) mem[s][r][c] = i2f($urandom_range(1, 15));
            end
        test_reset();
        test_row();
        test_col();
        test_diag(2'd0, 2'd0);
        test_diag(2'd1, 2'd2);
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_random_ready();
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL final_queue: got %0d pending, expected 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
